// File: rtl/controle_escrita.sv
// Purpose : in-order write-back queue merging memory-load and ALU results onto the register-file write port.
// Latency : an entry accepted at a clock edge is presented (write_reg=1) after the next clock edge.
// Backpressure: mem_ready/ula_ready come from registered free space only; a drain in the same cycle gives no credit.
//
// Ports:
//   clock, reset                    - clock and synchronous active-high reset
//   mem_valid/mem_end/mem_dados     - memory result offer; mem_ready accepts it
//   ula_valid/ula_end/ula_dados     - ALU result offer; ula_ready accepts it
//   write_reg/end_escrita/dados_escrita - register-file write strobe, address, data
//   consulta_end/pendente           - hazard query: is a write to this address queued or on the port
//   ocupacao                        - number of valid queue entries
module controle_escrita #(
  parameter int PROFUNDIDADE = 4  // power of two, at least 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mem_valid,
  input  logic [4:0]                    mem_end,
  input  logic [31:0]                   mem_dados,
  output logic                          mem_ready,
  input  logic                          ula_valid,
  input  logic [4:0]                    ula_end,
  input  logic [31:0]                   ula_dados,
  output logic                          ula_ready,
  output logic                          write_reg,
  output logic [4:0]                    end_escrita,
  output logic [31:0]                   dados_escrita,
  input  logic [4:0]                    consulta_end,
  output logic                          pendente,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] PROF_W = OW'(PROFUNDIDADE);

  typedef struct packed {
    logic [4:0]  ende;
    logic [31:0] dados;
  } entrada_t;

  entrada_t        fila_q [PROFUNDIDADE];
  entrada_t        fila_d [PROFUNDIDADE];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   ocupacao_q, ocupacao_d;
  logic            write_reg_q, write_reg_d;
  logic [4:0]      end_q, end_d;
  logic [31:0]     dados_q, dados_d;

  logic [OW-1:0]   livre;
  logic            mem_push, ula_push, pop;
  logic [AW-1:0]   ula_slot;
  logic [AW-1:0]   deslocamento;
  logic            achou;

  // Flow control and queue next-state
  always_comb begin
    livre       = PROF_W - ocupacao_q;
    mem_ready   = (livre >= OW'(1));
    // When memory is also offering, it takes the first free slot, so the
    // ALU needs a second one regardless of the memory address.
    ula_ready   = mem_valid ? (livre >= OW'(2)) : (livre >= OW'(1));

    // Register 0 writes complete the handshake but are dropped here.
    mem_push    = mem_valid && mem_ready && (mem_end != 5'd0);
    ula_push    = ula_valid && ula_ready && (ula_end != 5'd0);
    pop         = (ocupacao_q != '0);

    fila_d      = fila_q;
    ula_slot    = wr_ptr_q + AW'(mem_push);
    if (mem_push) begin
      fila_d[wr_ptr_q] = '{ende: mem_end, dados: mem_dados};
    end
    if (ula_push) begin
      fila_d[ula_slot] = '{ende: ula_end, dados: ula_dados};
    end

    // Pointer arithmetic wraps naturally because the depth is a power of two.
    wr_ptr_d    = wr_ptr_q + AW'(mem_push) + AW'(ula_push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    ocupacao_d  = ocupacao_q + OW'(mem_push) + OW'(ula_push) - OW'(pop);

    write_reg_d = pop;
    end_d       = end_q;
    dados_d     = dados_q;
    if (pop) begin
      end_d   = fila_q[rd_ptr_q].ende;
      dados_d = fila_q[rd_ptr_q].dados;
    end
  end

  // Hazard query: scan only the slots between the read pointer and occupancy.
  always_comb begin
    achou        = 1'b0;
    deslocamento = '0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      deslocamento = AW'(i) - rd_ptr_q;
      if (({1'b0, deslocamento} < ocupacao_q) && (fila_q[i].ende == consulta_end)) begin
        achou = 1'b1;
      end
    end
    pendente = (consulta_end != 5'd0) &&
               (achou || (write_reg_q && (end_q == consulta_end)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        fila_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ocupacao_q  <= '0;
      write_reg_q <= 1'b0;
      end_q       <= '0;
      dados_q     <= '0;
    end else begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        fila_q[i] <= fila_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ocupacao_q  <= ocupacao_d;
      write_reg_q <= write_reg_d;
      end_q       <= end_d;
      dados_q     <= dados_d;
    end
  end

  assign write_reg     = write_reg_q;
  assign end_escrita   = end_q;
  assign dados_escrita = dados_q;
  assign ocupacao      = ocupacao_q;

endmodule
